sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: three-port byte arbiter (loader > video > CPU) onto a
// 16-bit asynchronous SRAM with a fixed WAIT+1 cycle access window.
//
// Ports:
//   clock, reset          sole clock, synchronous active-low reset
//   ldBusy/ldWr/ldA/ldD   loader write port, ldOvf = sticky overflow
//   vidRd/vidA            video read strobe, vidQ/vidValid = result
//   cpuReq/cpuWe/cpuA/cpuD  CPU level request, cpuQ/cpuAck = result
//   sramUb/Lb/Oe/We       active-low SRAM strobes
//   sramA/sramDo/sramDoe  word address, write data, bus drive enable
//   sramDi                SRAM read data
module sram_arbiter #(
    parameter int AW   = 22,
    parameter int WAIT = 1
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          ldBusy,
    input  logic          ldWr,
    input  logic [AW-1:0] ldA,
    input  logic [7:0]    ldD,
    output logic          ldOvf,

    input  logic          vidRd,
    input  logic [AW-1:0] vidA,
    output logic [7:0]    vidQ,
    output logic          vidValid,

    input  logic          cpuReq,
    input  logic          cpuWe,
    input  logic [AW-1:0] cpuA,
    input  logic [7:0]    cpuD,
    output logic [7:0]    cpuQ,
    output logic          cpuAck,

    output logic          sramUb,
    output logic          sramLb,
    output logic          sramOe,
    output logic          sramWe,
    output logic [AW-2:0] sramA,
    output logic [15:0]   sramDo,
    output logic          sramDoe,
    input  logic [15:0]   sramDi
);

    typedef enum logic { IDLE, ACC } state_t;
    typedef enum logic [1:0] { SRC_LD, SRC_VID, SRC_CPU } src_t;

    state_t        state;
    state_t        stateNext;
    logic [2:0]    cnt;

    logic          ldPend;
    logic          vidPend;
    logic          cpuPend;
    logic [AW-1:0] ldAq;
    logic [AW-1:0] vidAq;
    logic [AW-1:0] cpuAq;
    logic [7:0]    ldDq;
    logic [7:0]    cpuDq;
    logic          cpuWeQ;

    src_t          curSrc;
    logic          curWe;
    logic [AW-1:0] curA;
    logic [7:0]    curD;

    logic          cpuReqQ;
    logic          ldBusyQ;

    logic          vidIn;
    logic          cpuRise;
    logic          slotFree;
    logic          accDone;
    logic          ldAny;
    logic          vidAny;
    logic          cpuAny;
    logic          grantLd;
    logic          grantVid;
    logic          grantCpu;
    logic          grant;
    logic [7:0]    rdByte;

    // A request seen on this edge competes for the slot right away, so an
    // idle arbiter starts the access one cycle after the strobe.
    always_comb begin
        vidIn    = vidRd & ~ldBusy;
        cpuRise  = cpuReq & ~cpuReqQ;
        slotFree = (state == IDLE) || (cnt == 3'd0);
        accDone  = (state == ACC) && (cnt == 3'd0);
        ldAny    = ldPend | ldWr;
        vidAny   = vidPend | vidIn;
        cpuAny   = (cpuPend | cpuRise) & ~ldBusy;
        grantLd  = slotFree & ldAny;
        grantVid = slotFree & ~ldAny & vidAny;
        grantCpu = slotFree & ~ldAny & ~vidAny & cpuAny;
        grant    = grantLd | grantVid | grantCpu;
        rdByte   = curA[0] ? sramDi[15:8] : sramDi[7:0];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (grant) begin
            stateNext = ACC;
        end else if (accDone) begin
            stateNext = IDLE;
        end
    end

    // Write enable releases on the last cycle so data is held past We rise.
    always_comb begin
        sramUb  = 1'b1;
        sramLb  = 1'b1;
        sramOe  = 1'b1;
        sramWe  = 1'b1;
        sramDoe = 1'b0;
        if (state == ACC) begin
            sramUb  = ~curA[0];
            sramLb  = curA[0];
            sramOe  = curWe;
            sramWe  = ~(curWe && (cnt != 3'd0));
            sramDoe = curWe;
        end
    end

    assign sramA  = curA[AW-1:1];
    assign sramDo = {curD, curD};

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt      <= 3'd0;
            ldPend   <= 1'b0;
            vidPend  <= 1'b0;
            cpuPend  <= 1'b0;
            ldAq     <= '0;
            vidAq    <= '0;
            cpuAq    <= '0;
            ldDq     <= 8'h00;
            cpuDq    <= 8'h00;
            cpuWeQ   <= 1'b0;
            curSrc   <= SRC_LD;
            curWe    <= 1'b0;
            curA     <= '0;
            curD     <= 8'h00;
            vidQ     <= 8'h00;
            cpuQ     <= 8'h00;
            vidValid <= 1'b0;
            cpuAck   <= 1'b0;
            ldOvf    <= 1'b0;
            // Track the levels through reset so a held line is not an edge.
            cpuReqQ  <= cpuReq;
            ldBusyQ  <= ldBusy;
        end else begin
            cpuReqQ  <= cpuReq;
            ldBusyQ  <= ldBusy;
            vidValid <= 1'b0;
            cpuAck   <= 1'b0;

            if ((state == ACC) && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end

            if (accDone) begin
                if (curSrc == SRC_VID) begin
                    vidValid <= 1'b1;
                    vidQ     <= rdByte;
                end
                if (curSrc == SRC_CPU) begin
                    cpuAck <= 1'b1;
                    if (!curWe) begin
                        cpuQ <= rdByte;
                    end
                end
            end

            if (grant) begin
                cnt <= 3'(WAIT);
            end
            if (grantLd) begin
                curSrc <= SRC_LD;
                curWe  <= 1'b1;
                curA   <= ldPend ? ldAq : ldA;
                curD   <= ldPend ? ldDq : ldD;
            end
            if (grantVid) begin
                curSrc <= SRC_VID;
                curWe  <= 1'b0;
                curA   <= vidPend ? vidAq : vidA;
                curD   <= 8'h00;
            end
            if (grantCpu) begin
                curSrc <= SRC_CPU;
                curWe  <= cpuPend ? cpuWeQ : cpuWe;
                curA   <= cpuPend ? cpuAq : cpuA;
                curD   <= cpuPend ? cpuDq : cpuD;
            end

            // An incoming strobe is consumed directly only when it wins the
            // slot with nothing latched; otherwise it (re)fills the latch.
            if (ldBusy && !ldBusyQ) begin
                ldOvf <= 1'b0;
            end
            if (ldWr && !(grantLd && !ldPend)) begin
                if (ldPend && !grantLd) begin
                    ldOvf <= 1'b1;
                end else begin
                    ldPend <= 1'b1;
                    ldAq   <= ldA;
                    ldDq   <= ldD;
                end
            end else if (grantLd) begin
                ldPend <= 1'b0;
            end

            if (vidIn && !(grantVid && !vidPend)) begin
                vidPend <= 1'b1;
                vidAq   <= vidA;
            end else if (grantVid) begin
                vidPend <= 1'b0;
            end

            if (cpuRise && !(grantCpu && !cpuPend)) begin
                cpuPend <= 1'b1;
                cpuAq   <= cpuA;
                cpuDq   <= cpuD;
                cpuWeQ  <= cpuWe;
            end else if (grantCpu) begin
                cpuPend <= 1'b0;
            end
        end
    end

endmodule
